ysyx_220053_mem_arbiter: RTL and testbench

- Shares one memory port between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Sits between the fetch stage, the LSU and the single memory-side interface (bus bridge or pmem wrapper).
- Issues one outstanding transaction at a time, routes the response back to the owner, and uses a round-robin priority so neither requester starves.

---
 rtl/ysyx_220053_mem_arbiter_if.sv | 49 ++++
 rtl/ysyx_220053_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ysyx_220053_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_mem_arbiter_if.sv
// Bundle of the IF, LS and memory-side handshake signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface ysyx_220053_mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [DATA_W-1:0] ls_wdata;
    logic [MASK_W-1:0] ls_wmask;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rdata,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rdata,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_220053_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the LSU,
// with a single outstanding transaction and response routing back to its owner.
module ysyx_220053_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_220053_mem_arbiter_if.slave       bus,
    output logic                           busy,
    output logic                           stray_rsp
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              last_grant_r;
    logic              lock_r;
    logic              lock_ls_r;
    logic              stray_r;

    logic              have_win_s;
    logic              win_ls_s;
    logic              xfer_s;
    logic              busy_s;
    logic              if_req_ready_s;
    logic              ls_req_ready_s;
    logic              if_rsp_valid_s;
    logic              ls_rsp_valid_s;
    logic [DATA_W-1:0] if_rdata_s;
    logic [DATA_W-1:0] ls_rdata_s;
    logic              mem_req_valid_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_wen_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [MASK_W-1:0] mem_wmask_s;

    // Arbitration, forwarding, response routing and next-state selection.
    always_comb begin
        state_nxt_s     = state_r;
        have_win_s      = 1'b0;
        win_ls_s        = 1'b0;
        busy_s          = 1'b0;
        if_req_ready_s  = 1'b0;
        ls_req_ready_s  = 1'b0;
        if_rsp_valid_s  = 1'b0;
        ls_rsp_valid_s  = 1'b0;
        if_rdata_s      = '0;
        ls_rdata_s      = '0;
        mem_req_valid_s = 1'b0;
        mem_addr_s      = '0;
        mem_wen_s       = 1'b0;
        mem_wdata_s     = '0;
        mem_wmask_s     = '0;
        case (state_r)
            IDLE: begin
                // A requester stalled by backpressure keeps the grant while it holds valid.
                if (lock_r && (lock_ls_r ? bus.ls_req_valid : bus.if_req_valid)) begin
                    have_win_s = 1'b1;
                    win_ls_s   = lock_ls_r;
                end else if (bus.if_req_valid && bus.ls_req_valid) begin
                    have_win_s = 1'b1;
                    win_ls_s   = ~last_grant_r;
                end else if (bus.if_req_valid) begin
                    have_win_s = 1'b1;
                    win_ls_s   = 1'b0;
                end else if (bus.ls_req_valid) begin
                    have_win_s = 1'b1;
                    win_ls_s   = 1'b1;
                end else begin
                    have_win_s = 1'b0;
                    win_ls_s   = 1'b0;
                end
                if (have_win_s && win_ls_s) begin
                    mem_req_valid_s = 1'b1;
                    mem_addr_s      = bus.ls_addr;
                    mem_wen_s       = bus.ls_wen;
                    mem_wdata_s     = bus.ls_wdata;
                    mem_wmask_s     = bus.ls_wmask;
                    ls_req_ready_s  = bus.mem_req_ready;
                end else if (have_win_s) begin
                    mem_req_valid_s = 1'b1;
                    mem_addr_s      = bus.if_addr;
                    if_req_ready_s  = bus.mem_req_ready;
                end else begin
                    mem_req_valid_s = 1'b0;
                end
                if (have_win_s && bus.mem_req_ready) begin
                    state_nxt_s = win_ls_s ? WAIT_LS : WAIT_IF;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_IF: begin
                busy_s = 1'b1;
                if (bus.mem_rsp_valid) begin
                    if_rsp_valid_s = 1'b1;
                    if_rdata_s     = bus.mem_rdata;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s    = WAIT_IF;
                end
            end
            WAIT_LS: begin
                busy_s = 1'b1;
                if (bus.mem_rsp_valid) begin
                    ls_rsp_valid_s = 1'b1;
                    ls_rdata_s     = bus.mem_rdata;
                    state_nxt_s    = IDLE;
                end else begin
                    state_nxt_s    = WAIT_LS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign xfer_s = mem_req_valid_s & bus.mem_req_ready;

    // State, round-robin history, stall lock and sticky stray-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            lock_r       <= 1'b0;
            lock_ls_r    <= 1'b0;
            stray_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (xfer_s) begin
                last_grant_r <= win_ls_s;
                lock_r       <= 1'b0;
            end else if (mem_req_valid_s) begin
                lock_r    <= 1'b1;
                lock_ls_r <= win_ls_s;
            end else begin
                lock_r    <= 1'b0;
            end
            if ((state_r == IDLE) && bus.mem_rsp_valid) begin
                stray_r <= 1'b1;
            end
        end
    end

    // Reset forces every output low at once, without waiting for a clock edge.
    assign bus.if_req_ready  = ~rst & if_req_ready_s;
    assign bus.ls_req_ready  = ~rst & ls_req_ready_s;
    assign bus.if_rsp_valid  = ~rst & if_rsp_valid_s;
    assign bus.ls_rsp_valid  = ~rst & ls_rsp_valid_s;
    assign bus.if_rdata      = rst ? '0 : if_rdata_s;
    assign bus.ls_rdata      = rst ? '0 : ls_rdata_s;
    assign bus.mem_req_valid = ~rst & mem_req_valid_s;
    assign bus.mem_addr      = rst ? '0 : mem_addr_s;
    assign bus.mem_wen       = ~rst & mem_wen_s;
    assign bus.mem_wdata     = rst ? '0 : mem_wdata_s;
    assign bus.mem_wmask     = rst ? '0 : mem_wmask_s;
    assign busy              = ~rst & busy_s;
    assign stray_rsp         = stray_r;
endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Directed bench for the memory arbiter: expected grants and responses are queued by
// the stimulus and checked by an independent monitor on the opposite clock edge.
module tb_ysyx_220053_mem_arbiter;
    logic clk;
    logic rst;
    logic busy;
    logic stray_rsp;
    int   checks;
    int   errors;

    typedef struct {
        logic [1:0]  who;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } grant_t;

    grant_t      grant_q[$];
    logic [63:0] if_exp_q[$];
    logic [63:0] ls_exp_q[$];
    grant_t      g;
    logic [63:0] d;

    ysyx_220053_mem_arbiter_if bus ();

    ysyx_220053_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .stray_rsp (stray_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic [1:0] who, input logic [63:0] addr, input logic wen,
                             input logic [63:0] wdata, input logic [7:0] wmask);
        grant_t e;
        e.who = who; e.addr = addr; e.wen = wen; e.wdata = wdata; e.wmask = wmask;
        grant_q.push_back(e);
    endtask

    task automatic mem_rsp(input logic [63:0] data);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = data;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every accepted request and every response must match the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (grant_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: addr %h", bus.mem_addr);
                end else begin
                    g = grant_q.pop_front();
                    cmp("grant_who", {62'h0, bus.ls_req_ready, bus.if_req_ready}, {62'h0, g.who});
                    cmp("grant_addr", bus.mem_addr, g.addr);
                    cmp("grant_wen", {63'h0, bus.mem_wen}, {63'h0, g.wen});
                    cmp("grant_wdata", bus.mem_wdata, g.wdata);
                    cmp("grant_wmask", {56'h0, bus.mem_wmask}, {56'h0, g.wmask});
                end
            end
            if (bus.if_rsp_valid) begin
                if (if_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_if_rsp: data %h", bus.if_rdata);
                end else begin
                    d = if_exp_q.pop_front();
                    cmp("if_rdata", bus.if_rdata, d);
                    cmp("ls_rsp_quiet", {63'h0, bus.ls_rsp_valid}, 64'h0);
                    cmp("ls_rdata_zero", bus.ls_rdata, 64'h0);
                end
            end
            if (bus.ls_rsp_valid) begin
                if (ls_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ls_rsp: data %h", bus.ls_rdata);
                end else begin
                    d = ls_exp_q.pop_front();
                    cmp("ls_rdata", bus.ls_rdata, d);
                    cmp("if_rdata_zero", bus.if_rdata, 64'h0);
                end
            end
        end
    end

    initial begin
        int if_n;
        int ls_n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0000;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = 64'h0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = 64'h0;
        bus.ls_wmask      = 8'h00;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'h0;

        // Reset state: outputs held at zero even with a valid request pending
        @(negedge clk);
        cmp("rst_mem_req_valid", {63'h0, bus.mem_req_valid}, 64'h0);
        cmp("rst_if_req_ready", {63'h0, bus.if_req_ready}, 64'h0);
        cmp("rst_mem_addr", bus.mem_addr, 64'h0);
        cmp("rst_busy", {63'h0, busy}, 64'h0);
        cmp("rst_stray", {63'h0, stray_rsp}, 64'h0);
        bus.if_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Test 1: IF-only read, response two cycles after acceptance
        exp_grant(2'b01, 64'h8000_0000, 1'b0, 64'h0, 8'h00);
        if_exp_q.push_back(64'h0000_0413);
        bus.if_req_valid = 1'b1;
        tick();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        cmp("t1_busy", {63'h0, busy}, 64'h1);
        tick();
        mem_rsp(64'h0000_0413);

        // Test 2: simultaneous requests right after reset, IF first
        pulse_reset();
        exp_grant(2'b01, 64'h8000_0004, 1'b0, 64'h0, 8'h00);
        exp_grant(2'b10, 64'h8000_1000, 1'b0, 64'h0, 8'h00);
        if_exp_q.push_back(64'h0010_0093);
        ls_exp_q.push_back(64'h1122_3344_5566_7788);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        tick();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        cmp("t2_ls_blocked", {63'h0, bus.ls_req_ready}, 64'h0);
        mem_rsp(64'h0010_0093);
        @(negedge clk);
        cmp("t2_ls_ready", {63'h0, bus.ls_req_ready}, 64'h1);
        tick();
        bus.ls_req_valid = 1'b0;
        mem_rsp(64'h1122_3344_5566_7788);

        // Test 3: sustained contention, grants must alternate starting with IF
        if_n = 0;
        ls_n = 0;
        bus.if_req_valid = 1'b1;
        bus.ls_req_valid = 1'b1;
        bus.ls_wen       = 1'b1;
        bus.ls_wmask     = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            bus.if_addr  = 64'h8000_0100 + 64'(8 * if_n);
            bus.ls_addr  = 64'h8000_3000 + 64'(8 * ls_n);
            bus.ls_wdata = 64'hA5A5_0000 + 64'(ls_n);
            if (k % 2 == 1) begin
                exp_grant(2'b10, bus.ls_addr, 1'b1, bus.ls_wdata, 8'hFF);
                ls_exp_q.push_back(64'hC0DE_0000 + 64'(k));
                ls_n++;
            end else begin
                exp_grant(2'b01, bus.if_addr, 1'b0, 64'h0, 8'h00);
                if_exp_q.push_back(64'hC0DE_0000 + 64'(k));
                if_n++;
            end
            tick();
            mem_rsp(64'hC0DE_0000 + 64'(k));
        end
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;

        // Test 4: LS write stalled by backpressure while IF raises valid
        bus.mem_req_ready = 1'b0;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_2000;
        bus.ls_wen        = 1'b1;
        bus.ls_wdata      = 64'hDEAD_BEEF;
        bus.ls_wmask      = 8'h0F;
        exp_grant(2'b10, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        exp_grant(2'b01, 64'h8000_0200, 1'b0, 64'h0, 8'h00);
        ls_exp_q.push_back(64'h1);
        if_exp_q.push_back(64'hFFFF_0001);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            cmp("t4_stall_valid", {63'h0, bus.mem_req_valid}, 64'h1);
            cmp("t4_stall_addr", bus.mem_addr, 64'h8000_2000);
            cmp("t4_stall_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
            cmp("t4_stall_wmask", {56'h0, bus.mem_wmask}, 64'h0F);
            cmp("t4_stall_wen", {63'h0, bus.mem_wen}, 64'h1);
            cmp("t4_if_not_ready", {63'h0, bus.if_req_ready}, 64'h0);
            tick();
            bus.if_req_valid = 1'b1;
            bus.if_addr      = 64'h8000_0200;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        cmp("t4_ls_ready", {63'h0, bus.ls_req_ready}, 64'h1);
        tick();
        bus.ls_req_valid = 1'b0;
        bus.ls_wen       = 1'b0;
        bus.ls_wdata     = 64'h0;
        bus.ls_wmask     = 8'h00;
        mem_rsp(64'h1);
        tick();
        bus.if_req_valid = 1'b0;
        mem_rsp(64'hFFFF_0001);

        // Test 5: async reset while LS is outstanding, then a late response
        exp_grant(2'b10, 64'h8000_4000, 1'b0, 64'h0, 8'h00);
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_4000;
        tick();
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        cmp("t5_busy_before", {63'h0, busy}, 64'h1);
        tick();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0300;
        #2;
        rst = 1'b1;
        #1;
        cmp("t5_rst_busy", {63'h0, busy}, 64'h0);
        cmp("t5_rst_mem_valid", {63'h0, bus.mem_req_valid}, 64'h0);
        cmp("t5_rst_if_ready", {63'h0, bus.if_req_ready}, 64'h0);
        cmp("t5_rst_mem_addr", bus.mem_addr, 64'h0);
        bus.if_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmp("t5_idle_busy", {63'h0, busy}, 64'h0);
        cmp("t5_stray_clear", {63'h0, stray_rsp}, 64'h0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 64'hBAD0_0BAD;
        @(negedge clk);
        cmp("t5_no_ls_rsp", {63'h0, bus.ls_rsp_valid}, 64'h0);
        cmp("t5_no_if_rsp", {63'h0, bus.if_rsp_valid}, 64'h0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'h0;
        @(negedge clk);
        cmp("t5_stray_set", {63'h0, stray_rsp}, 64'h1);
        cmp("t5_still_idle", {63'h0, busy}, 64'h0);

        // Test 6: response and new LS request in the same cycle
        tick();
        exp_grant(2'b10, 64'h8000_5000, 1'b0, 64'h0, 8'h00);
        exp_grant(2'b10, 64'h8000_5008, 1'b0, 64'h0, 8'h00);
        ls_exp_q.push_back(64'h5555);
        ls_exp_q.push_back(64'h6666);
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_5000;
        tick();
        bus.ls_req_valid = 1'b0;
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 64'h5555;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_5008;
        @(negedge clk);
        cmp("t6_overlap_ready", {63'h0, bus.ls_req_ready}, 64'h0);
        cmp("t6_overlap_busy", {63'h0, busy}, 64'h1);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 64'h0;
        @(negedge clk);
        cmp("t6_next_ready", {63'h0, bus.ls_req_ready}, 64'h1);
        cmp("t6_idle_busy", {63'h0, busy}, 64'h0);
        tick();
        bus.ls_req_valid = 1'b0;
        @(negedge clk);
        cmp("t6_busy_again", {63'h0, busy}, 64'h1);
        tick();
        mem_rsp(64'h6666);

        tick();
        tick();
        cmp("grant_q_drained", 64'(grant_q.size()), 64'h0);
        cmp("if_q_drained", 64'(if_exp_q.size()), 64'h0);
        cmp("ls_q_drained", 64'(ls_exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
